uart_apb_regif: RTL and testbench

APB3 responder and register file for the UART core. It decodes APB reads and writes from the host bus into the THR/RBR/IER/IIR/FCR/LCR/LSR registers. It pushes transmit bytes into the TX FIFO, pops received bytes from the RX FIFO, keeps sticky line-status flags, and drives the level interrupt. It sits between the APB fabric and the TX/RX datapaths inside uart_top.

---
 rtl/uart_pkg.sv | 51 +++++
 rtl/uart_irq_prio.sv | 28 ++
 rtl/uart_apb_regif.sv | 199 +++++++++++++++++++
 tb/tb_uart_apb_regif.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART APB register interface: register offsets,
// LSR bit positions, IIR codes and the APB responder state encoding.
package uart_pkg;

  // Register offsets within the decoded address window
  localparam logic [7:0] THR_RBR = 8'h00;
  localparam logic [7:0] IER     = 8'h04;
  localparam logic [7:0] IIR_FCR = 8'h08;
  localparam logic [7:0] LCR     = 8'h0C;
  localparam logic [7:0] LSR     = 8'h14;

  // LSR bit positions
  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_PE   = 2;
  localparam int LSR_FE   = 3;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;

  // IIR codes, highest priority first
  localparam logic [7:0] IIR_LINE_STATUS = 8'h06;
  localparam logic [7:0] IIR_RX_DATA     = 8'h04;
  localparam logic [7:0] IIR_THR_EMPTY   = 8'h02;
  localparam logic [7:0] IIR_NONE        = 8'h01;

  // Reset value of the line control register (8 data bits, 1 stop, no parity)
  localparam logic [7:0] LCR_RESET = 8'h03;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_END    = 2'd2
  } apb_state_e;

  // Assemble the LSR image; sticky = {FE, PE, OE}
  function automatic logic [7:0] lsr_pack(input logic       dr,
                                          input logic [2:0] sticky,
                                          input logic       thre,
                                          input logic       temt);
    logic [7:0] v;
    v           = 8'h00;
    v[LSR_DR]   = dr;
    v[LSR_OE]   = sticky[0];
    v[LSR_PE]   = sticky[1];
    v[LSR_FE]   = sticky[2];
    v[LSR_THRE] = thre;
    v[LSR_TEMT] = temt;
    return v;
  endfunction

endpackage

// File: rtl/uart_irq_prio.sv
// Interrupt identification encoder: picks the highest-priority enabled
// interrupt source and reports it as an IIR code plus a level irq.
module uart_irq_prio
  import uart_pkg::*;
(
  input  logic [2:0] ier_i,     // [0] rx data, [1] thr empty, [2] line status
  input  logic       dr_i,
  input  logic       thre_i,
  input  logic [2:0] sticky_i,  // {FE, PE, OE}
  output logic [7:0] iir_o,
  output logic       irq_o
);

  // Priority chain: line status errors, then received data, then THR empty
  always_comb begin
    iir_o = IIR_NONE;
    if (ier_i[2] && (|sticky_i)) begin
      iir_o = IIR_LINE_STATUS;
    end else if (ier_i[0] && dr_i) begin
      iir_o = IIR_RX_DATA;
    end else if (ier_i[1] && thre_i) begin
      iir_o = IIR_THR_EMPTY;
    end
  end

  assign irq_o = (iir_o != IIR_NONE);

endmodule

// File: rtl/uart_apb_regif.sv
// APB3 responder and register file for the UART core. Decodes host accesses
// into THR/RBR/IER/IIR/FCR/LCR/LSR, issues one-cycle FIFO strobes, keeps the
// sticky line-status flags and drives the level interrupt.
module uart_apb_regif
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_LSB_BITS = 8
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [31:0]           paddr,
  input  logic [31:0]           pwdata,
  input  logic                  pwrite,
  input  logic                  psel,
  input  logic                  penable,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  tx_push,
  output logic [DATA_WIDTH-1:0] tx_wdata,
  input  logic                  tx_full,
  input  logic                  tx_empty,
  input  logic                  tx_busy,
  output logic                  rx_pop,
  input  logic [DATA_WIDTH-1:0] rx_rdata,
  input  logic                  rx_empty,
  input  logic                  rx_pe_set,
  input  logic                  rx_fe_set,
  input  logic                  rx_oe_set,
  output logic                  fifo_clr_tx,
  output logic                  fifo_clr_rx,
  output logic [7:0]            lcr,
  output logic                  irq
);

  localparam logic [ADDR_LSB_BITS-1:0] A_THR_RBR = ADDR_LSB_BITS'(THR_RBR);
  localparam logic [ADDR_LSB_BITS-1:0] A_IER     = ADDR_LSB_BITS'(IER);
  localparam logic [ADDR_LSB_BITS-1:0] A_IIR_FCR = ADDR_LSB_BITS'(IIR_FCR);
  localparam logic [ADDR_LSB_BITS-1:0] A_LCR     = ADDR_LSB_BITS'(LCR);
  localparam logic [ADDR_LSB_BITS-1:0] A_LSR     = ADDR_LSB_BITS'(LSR);

  apb_state_e              state_q;
  logic                    pready_q, pslverr_q;
  logic [31:0]             prdata_q;
  logic                    tx_push_q, rx_pop_q, clr_tx_q, clr_rx_q;
  logic [DATA_WIDTH-1:0]   tx_wdata_q;
  logic [2:0]              ier_q;
  logic [7:0]              lcr_q;
  logic [2:0]              sticky_q, sticky_d;  // {FE, PE, OE}

  logic [ADDR_LSB_BITS-1:0] offset;
  logic                     access_start;
  logic [7:0]               lsr_val;
  logic [7:0]               iir_val;
  logic                     irq_w;

  logic                     dec_err, dec_push, dec_pop, dec_clr_rx, dec_clr_tx;
  logic                     dec_ier_wr, dec_lcr_wr, dec_lsr_rd;
  logic [31:0]              dec_rdata;

  // Address bits above the decoded window and write data above the byte lane
  // carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{paddr[31:ADDR_LSB_BITS], pwdata[31:8]};

  assign offset       = paddr[ADDR_LSB_BITS-1:0];
  assign access_start = (state_q == ST_IDLE) && psel && penable;
  assign lsr_val      = lsr_pack(!rx_empty, sticky_q, tx_empty, tx_empty & ~tx_busy);

  uart_irq_prio u_irq_prio (
    .ier_i    (ier_q),
    .dr_i     (!rx_empty),
    .thre_i   (tx_empty),
    .sticky_i (sticky_q),
    .iir_o    (iir_val),
    .irq_o    (irq_w)
  );

  // Decode the current access into its response and side effects
  always_comb begin
    dec_err    = 1'b0;
    dec_rdata  = 32'h0;
    dec_push   = 1'b0;
    dec_pop    = 1'b0;
    dec_clr_rx = 1'b0;
    dec_clr_tx = 1'b0;
    dec_ier_wr = 1'b0;
    dec_lcr_wr = 1'b0;
    dec_lsr_rd = 1'b0;
    if (pwrite) begin
      case (offset)
        A_THR_RBR: begin
          if (tx_full) dec_err  = 1'b1;  // byte dropped, master told so
          else         dec_push = 1'b1;
        end
        A_IER:     dec_ier_wr = 1'b1;
        A_IIR_FCR: begin
          dec_clr_rx = pwdata[1];
          dec_clr_tx = pwdata[2];
        end
        A_LCR:     dec_lcr_wr = 1'b1;
        default:   dec_err    = 1'b1;    // includes LSR, which is read-only
      endcase
    end else begin
      case (offset)
        A_THR_RBR: begin
          // An empty FIFO reads as zero without error or pop
          if (!rx_empty) begin
            dec_rdata = {{(32-DATA_WIDTH){1'b0}}, rx_rdata};
            dec_pop   = 1'b1;
          end
        end
        A_IER:     dec_rdata = {29'h0, ier_q};
        A_IIR_FCR: dec_rdata = {24'h0, iir_val};
        A_LCR:     dec_rdata = {24'h0, lcr_q};
        A_LSR: begin
          dec_rdata  = {24'h0, lsr_val};
          dec_lsr_rd = 1'b1;
        end
        default:   dec_err = 1'b1;
      endcase
    end
  end

  // APB handshake FSM with registered response and single-cycle strobes
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= ST_IDLE;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= 32'h0;
      tx_push_q  <= 1'b0;
      tx_wdata_q <= '0;
      rx_pop_q   <= 1'b0;
      clr_tx_q   <= 1'b0;
      clr_rx_q   <= 1'b0;
      ier_q      <= 3'b000;
      lcr_q      <= LCR_RESET;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 32'h0;
      tx_push_q <= 1'b0;
      rx_pop_q  <= 1'b0;
      clr_tx_q  <= 1'b0;
      clr_rx_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (psel && penable) begin
            state_q   <= ST_ACCESS;
            pready_q  <= 1'b1;
            pslverr_q <= dec_err;
            prdata_q  <= dec_rdata;
            tx_push_q <= dec_push;
            rx_pop_q  <= dec_pop;
            clr_rx_q  <= dec_clr_rx;
            clr_tx_q  <= dec_clr_tx;
            if (dec_push)   tx_wdata_q <= pwdata[DATA_WIDTH-1:0];
            if (dec_ier_wr) ier_q      <= pwdata[2:0];
            if (dec_lcr_wr) lcr_q      <= pwdata[7:0];
          end
        end
        ST_ACCESS: state_q <= ST_END;
        ST_END: begin
          // Wait for the master to close the transfer so a held penable
          // cannot complete it twice
          if (!psel || !penable) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sticky flags: a completing LSR read clears them, a coincident set wins
  always_comb begin
    sticky_d = sticky_q;
    if (access_start && dec_lsr_rd) sticky_d = 3'b000;
    sticky_d = sticky_d | {rx_fe_set, rx_pe_set, rx_oe_set};
  end

  // Sticky flag register
  always_ff @(posedge pclk) begin
    if (preset) sticky_q <= 3'b000;
    else        sticky_q <= sticky_d;
  end

  assign prdata      = prdata_q;
  assign pready      = pready_q;
  assign pslverr     = pslverr_q;
  assign tx_push     = tx_push_q;
  assign tx_wdata    = tx_wdata_q;
  assign rx_pop      = rx_pop_q;
  assign fifo_clr_tx = clr_tx_q;
  assign fifo_clr_rx = clr_rx_q;
  assign lcr         = lcr_q;
  assign irq         = irq_w;

endmodule

// File: tb/tb_uart_apb_regif.sv
// Scoreboard bench for uart_apb_regif: stimulus pushes the expected response
// of each APB transfer; a monitor pops and compares whenever pready is seen.
module tb_uart_apb_regif;

  logic        pclk = 1'b0;
  logic        preset;
  logic [31:0] paddr, pwdata;
  logic        pwrite, psel, penable;
  logic [31:0] prdata;
  logic        pready, pslverr, tx_push, rx_pop, fifo_clr_tx, fifo_clr_rx, irq;
  logic [7:0]  tx_wdata, rx_rdata, lcr;
  logic        tx_full, tx_empty, tx_busy, rx_empty;
  logic        rx_pe_set, rx_fe_set, rx_oe_set;

  uart_apb_regif #(.DATA_WIDTH(8), .ADDR_LSB_BITS(8)) dut (
    .pclk(pclk), .preset(preset), .paddr(paddr), .pwdata(pwdata),
    .pwrite(pwrite), .psel(psel), .penable(penable), .prdata(prdata),
    .pready(pready), .pslverr(pslverr), .tx_push(tx_push), .tx_wdata(tx_wdata),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy), .rx_pop(rx_pop),
    .rx_rdata(rx_rdata), .rx_empty(rx_empty), .rx_pe_set(rx_pe_set),
    .rx_fe_set(rx_fe_set), .rx_oe_set(rx_oe_set), .fifo_clr_tx(fifo_clr_tx),
    .fifo_clr_rx(fifo_clr_rx), .lcr(lcr), .irq(irq)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] prdata;
    logic        pslverr;
    logic        push;
    logic [7:0]  wdata;
    logic        pop;
    logic        clr_rx;
    logic        clr_tx;
    logic [7:0]  lcr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   stray  = 0;
  int   pready_cnt = 0;

  // Reference model state
  logic [2:0] m_ier;
  logic [7:0] m_lcr;
  logic       m_oe, m_pe, m_fe;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
    end
  endtask

  function automatic logic [7:0] m_lsr();
    int v;
    v = (rx_empty ? 0 : 1) + 2 * m_oe + 4 * m_pe + 8 * m_fe
      + 32 * tx_empty + 64 * (tx_empty && !tx_busy);
    return 8'(v);
  endfunction

  function automatic logic [7:0] m_iir();
    if (m_ier[2] && (m_oe || m_pe || m_fe)) return 8'h06;
    if (m_ier[0] && !rx_empty)              return 8'h04;
    if (m_ier[1] && tx_empty)               return 8'h02;
    return 8'h01;
  endfunction

  task automatic model_reset();
    m_ier = 3'b000; m_lcr = 8'h03; m_oe = 1'b0; m_pe = 1'b0; m_fe = 1'b0;
  endtask

  // Expected outcome of one access from the register map rules; updates the model
  function automatic exp_t build_exp(input logic [31:0] addr, input logic wr,
                                     input logic [31:0] data);
    exp_t e;
    logic [7:0] off;
    e = '0;
    e.addr = addr;
    e.wr   = wr;
    off    = addr[7:0];
    if (wr) begin
      case (off)
        8'h00: if (tx_full) e.pslverr = 1'b1; else begin e.push = 1'b1; e.wdata = data[7:0]; end
        8'h04: m_ier = data[2:0];
        8'h08: begin e.clr_rx = data[1]; e.clr_tx = data[2]; end
        8'h0C: m_lcr = data[7:0];
        default: e.pslverr = 1'b1;
      endcase
    end else begin
      case (off)
        8'h00: if (!rx_empty) begin e.prdata = {24'h0, rx_rdata}; e.pop = 1'b1; end
        8'h04: e.prdata = {29'h0, m_ier};
        8'h08: e.prdata = {24'h0, m_iir()};
        8'h0C: e.prdata = {24'h0, m_lcr};
        8'h14: begin
          e.prdata = {24'h0, m_lsr()};
          m_oe = 1'b0; m_pe = 1'b0; m_fe = 1'b0;
        end
        default: e.pslverr = 1'b1;
      endcase
    end
    e.lcr = m_lcr;
    return e;
  endfunction

  // One APB transfer; hold = edges penable stays high once sampled (2 = normal)
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                          input bit fe_same_cycle, input int hold);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1;
    if (fe_same_cycle) rx_fe_set = 1'b1;
    exp_q.push_back(build_exp(addr, wr, data));
    if (fe_same_cycle) m_fe = 1'b1;
    @(posedge pclk); #1;
    rx_fe_set = 1'b0;
    repeat (hold - 1) @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] mask);  // {fe, pe, oe}
    @(posedge pclk); #1;
    rx_oe_set = mask[0]; rx_pe_set = mask[1]; rx_fe_set = mask[2];
    if (mask[0]) m_oe = 1'b1;
    if (mask[1]) m_pe = 1'b1;
    if (mask[2]) m_fe = 1'b1;
    @(posedge pclk); #1;
    rx_oe_set = 1'b0; rx_pe_set = 1'b0; rx_fe_set = 1'b0;
  endtask

  task automatic chk_irq();
    #1;
    chk("irq", {31'h0, irq}, {31'h0, (m_iir() != 8'h01)});
  endtask

  // Monitor: compare every completed transfer against the scoreboard
  always @(negedge pclk) begin
    if (pready) begin
      pready_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pready: got pready=1 expected no transfer pending");
      end else begin
        mon_e = exp_q.pop_front();
        $display("txn %s addr=0x%08h prdata=0x%08h pslverr=%0b push=%0b pop=%0b",
                 mon_e.wr ? "WR" : "RD", mon_e.addr, prdata, pslverr, tx_push, rx_pop);
        chk("prdata",  prdata, mon_e.prdata);
        chk("pslverr", {31'h0, pslverr}, {31'h0, mon_e.pslverr});
        chk("tx_push", {31'h0, tx_push}, {31'h0, mon_e.push});
        chk("rx_pop",  {31'h0, rx_pop},  {31'h0, mon_e.pop});
        chk("fifo_clr_rx", {31'h0, fifo_clr_rx}, {31'h0, mon_e.clr_rx});
        chk("fifo_clr_tx", {31'h0, fifo_clr_tx}, {31'h0, mon_e.clr_tx});
        chk("lcr", {24'h0, lcr}, {24'h0, mon_e.lcr});
        if (mon_e.push) chk("tx_wdata", {24'h0, tx_wdata}, {24'h0, mon_e.wdata});
      end
    end else if (tx_push || rx_pop || fifo_clr_tx || fifo_clr_rx) begin
      stray++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          p0;
    logic [31:0] r, a, d;
    logic [7:0]  offs [10];
    offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h02, 8'hFC, 8'h0D};

    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'h0; pwdata = 32'h0;
    tx_full = 1'b0; tx_empty = 1'b1; tx_busy = 1'b0; rx_empty = 1'b1; rx_rdata = 8'h00;
    rx_pe_set = 1'b0; rx_fe_set = 1'b0; rx_oe_set = 1'b0;
    model_reset();
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_pready",  {31'h0, pready},  32'h0);
    chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
    chk("rst_prdata",  prdata, 32'h0);
    chk("rst_strobes", {28'h0, tx_push, rx_pop, fifo_clr_tx, fifo_clr_rx}, 32'h0);
    chk("rst_lcr",     {24'h0, lcr}, 32'h3);
    chk("rst_irq",     {31'h0, irq}, 32'h0);
    @(posedge pclk); #1;
    preset = 1'b0;

    // Reset register values
    apb_xfer(32'h0C, 1'b0, 32'h0, 1'b0, 2);
    apb_xfer(32'h14, 1'b0, 32'h0, 1'b0, 2);
    apb_xfer(32'h08, 1'b0, 32'h0, 1'b0, 2);
    chk_irq();

    // THR writes with room and with a full FIFO
    apb_xfer(32'h00, 1'b1, 32'h55, 1'b0, 2);
    tx_full = 1'b1;
    apb_xfer(32'h00, 1'b1, 32'h55, 1'b0, 2);
    tx_full = 1'b0;

    // RBR read pops, then LSR with the FIFO empty again
    rx_empty = 1'b0; rx_rdata = 8'hA3;
    apb_xfer(32'h00, 1'b0, 32'h0, 1'b0, 2);
    rx_empty = 1'b1;
    apb_xfer(32'h14, 1'b0, 32'h0, 1'b0, 2);
    apb_xfer(32'h00, 1'b0, 32'h0, 1'b0, 2);

    // Sticky FE: set, read-clear, coincident set wins
    pulse(3'b100);
    apb_xfer(32'h14, 1'b0, 32'h0, 1'b0, 2);
    apb_xfer(32'h14, 1'b0, 32'h0, 1'b0, 2);
    pulse(3'b100);
    apb_xfer(32'h14, 1'b0, 32'h0, 1'b1, 2);
    apb_xfer(32'h14, 1'b0, 32'h0, 1'b0, 2);
    apb_xfer(32'h14, 1'b0, 32'h0, 1'b0, 2);

    // Interrupt priority
    apb_xfer(32'h04, 1'b1, 32'h07, 1'b0, 2);
    rx_empty = 1'b0; tx_empty = 1'b1;
    apb_xfer(32'h08, 1'b0, 32'h0, 1'b0, 2);
    chk_irq();
    pulse(3'b001);
    apb_xfer(32'h08, 1'b0, 32'h0, 1'b0, 2);
    chk_irq();
    apb_xfer(32'h14, 1'b0, 32'h0, 1'b0, 2);
    rx_empty = 1'b1;
    chk_irq();

    // Master holds psel&penable for four edges: exactly one completion
    p0 = pready_cnt;
    apb_xfer(32'h0C, 1'b1, 32'h1B, 1'b0, 4);
    repeat (3) @(posedge pclk);
    chk("hold_pready_pulses", pready_cnt - p0, 32'd1);

    // Unmapped, misaligned and read-only targets
    apb_xfer(32'h10, 1'b0, 32'h0, 1'b0, 2);
    apb_xfer(32'h10, 1'b1, 32'hFF, 1'b0, 2);
    apb_xfer(32'h0D, 1'b1, 32'hFF, 1'b0, 2);
    apb_xfer(32'h14, 1'b1, 32'hFF, 1'b0, 2);
    apb_xfer(32'h08, 1'b1, 32'h06, 1'b0, 2);

    // Reset sampled together with the access phase: no completion, no strobe
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h0; pwrite = 1'b1; pwdata = 32'h77;
    @(posedge pclk); #1;
    penable = 1'b1; preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    model_reset();
    @(negedge pclk);
    chk("rst_entry_pready",  {31'h0, pready},  32'h0);
    chk("rst_entry_tx_push", {31'h0, tx_push}, 32'h0);

    // Reset during the ACCESS cycle: pready gone on the next cycle
    apb_xfer(32'h04, 1'b1, 32'h03, 1'b0, 2);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h0; pwrite = 1'b1; pwdata = 32'h5A;
    @(posedge pclk); #1;
    penable = 1'b1;
    exp_q.push_back(build_exp(32'h0, 1'b1, 32'h5A));
    @(posedge pclk); #1;
    preset = 1'b1;
    @(posedge pclk); #1;
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    model_reset();
    @(negedge pclk);
    chk("rst_access_pready",  {31'h0, pready},  32'h0);
    chk("rst_access_tx_push", {31'h0, tx_push}, 32'h0);
    apb_xfer(32'h04, 1'b0, 32'h0, 1'b0, 2);
    apb_xfer(32'h0C, 1'b0, 32'h0, 1'b0, 2);

    // Randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      tx_full  = 1'($urandom_range(0, 1));
      tx_empty = 1'($urandom_range(0, 1));
      tx_busy  = 1'($urandom_range(0, 1));
      rx_empty = 1'($urandom_range(0, 1));
      rx_rdata = 8'($urandom());
      if ($urandom_range(0, 3) == 0) pulse(3'($urandom_range(1, 7)));
      r = $urandom();
      a = {r[31:8], offs[$urandom_range(0, 9)]};
      d = $urandom();
      apb_xfer(a, 1'($urandom_range(0, 1)), d, 1'b0, 2);
      chk_irq();
    end

    repeat (4) @(posedge pclk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    chk("stray_strobes", stray, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
